// File: rtl/store_buf.sv
// Store buffer: a DEPTH-entry FIFO between the MEM stage and data memory, with byte-lane
// formatting at enqueue. Define STORE_ALIGN_CHK_EN to reject misaligned sw/sh with a misalign pulse.
module store_buf #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    input  logic [1:0]               st_op,
    output logic                     mem_req,
    input  logic                     mem_ack,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_be,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     misalign
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [31:0]     r_mem_addr;
    logic [31:0]     r_mem_wdata;
    logic [3:0]      r_mem_be;

    logic [31:0]     r_addr_q  [DEPTH];
    logic [31:0]     r_wdata_q [DEPTH];
    logic [3:0]      r_be_q    [DEPTH];

    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic            w_bypass;
    logic [CW-1:0]   w_count_nxt;
    logic [PW-1:0]   w_rd_ptr_nxt;
    logic [31:0]     w_ent_addr;
    logic [31:0]     w_ent_wdata;
    logic [3:0]      w_ent_be;

    assign st_ready  = (r_count != CW'(DEPTH));
    assign w_accept  = st_valid && st_ready;
    assign w_pop     = (r_state == S_ISSUE) && mem_ack;
    assign mem_req   = (r_state == S_ISSUE);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign count     = r_count;

`ifdef STORE_ALIGN_CHK_EN
    logic w_misaligned;
    logic r_misalign;

    always_comb begin
        case (st_op)
            2'b01:   w_misaligned = 1'b0;
            2'b10:   w_misaligned = st_addr[0];
            default: w_misaligned = |st_addr[1:0];
        endcase
    end

    assign w_push   = w_accept && !w_misaligned;
    assign misalign = r_misalign;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_misalign <= 1'b0;
        else          r_misalign <= w_accept && w_misaligned;
    end
`else
    assign w_push   = w_accept;
    assign misalign = 1'b0;
`endif

    // Lane formatting: narrow stores are replicated across the word so any lane can be enabled.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_ent_addr  = {st_addr[31:2], 2'b00};
        w_ent_wdata = st_data;
        w_ent_be    = 4'b1111;
        case (st_op)
            2'b01: begin
                w_ent_be    = 4'b0001 << st_addr[1:0];
                w_ent_wdata = {4{st_data[7:0]}};
            end
            2'b10: begin
                w_ent_be    = st_addr[1] ? 4'b1100 : 4'b0011;
                w_ent_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_count_nxt  = r_count + CW'(w_push) - CW'(w_pop);
    assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
    // The next head is the entry being written when the buffer is (or is becoming) empty.
    assign w_bypass     = w_push && (r_count == CW'(w_pop));

    // NOTE: storage is left unreset; it is only ever read behind a non-zero count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_q[r_wr_ptr]  <= w_ent_addr;
            r_wdata_q[r_wr_ptr] <= w_ent_wdata;
            r_be_q[r_wr_ptr]    <= w_ent_be;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            r_count  <= w_count_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;

            if (w_count_nxt != '0) begin
                r_state <= S_ISSUE;
                if (w_bypass) begin
                    r_mem_addr  <= w_ent_addr;
                    r_mem_wdata <= w_ent_wdata;
                    r_mem_be    <= w_ent_be;
                end else begin
                    r_mem_addr  <= r_addr_q[w_rd_ptr_nxt];
                    r_mem_wdata <= r_wdata_q[w_rd_ptr_nxt];
                    r_mem_be    <= r_be_q[w_rd_ptr_nxt];
                end
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_store_buf.sv
// Directed bench for store_buf (DEPTH=2): formatting, backpressure, ordering,
// simultaneous push/pop, asynchronous reset and the misaligned-sw case.
module tb_store_buf;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_op;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [1:0]  count;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    store_buf #(.DEPTH(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_op     (st_op),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .count     (count),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        st_valid = v;
        st_op    = op;
        st_addr  = a;
        st_data  = d;
    endtask

    initial begin
        reset_n = 1'b0;
        mem_ack = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        #1;
        check("rst_req",    32'(mem_req),  32'd0);
        check("rst_count",  32'(count),    32'd0);
        check("rst_ready",  32'(st_ready), 32'd1);
        check("rst_addr",   mem_addr,      32'h0);
        check("rst_wdata",  mem_wdata,     32'h0);
        check("rst_be",     32'(mem_be),   32'h0);
        check("rst_mis",    32'(misalign), 32'd0);

        // sb 0x13 <- 0xAB with mem_ack held high; accepted on the first edge after reset.
        #11;
        reset_n = 1'b1;
        mem_ack = 1'b1;
        drive(1'b1, 2'b01, 32'h0000_0013, 32'h0000_00AB);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check("sb_req",   32'(mem_req),  32'd1);
        check("sb_addr",  mem_addr,      32'h0000_0010);
        check("sb_be",    32'(mem_be),   32'b1000);
        check("sb_wdata", mem_wdata,     32'hABAB_ABAB);
        step();
        check("sb_pop_count", 32'(count),   32'd0);
        check("sb_pop_req",   32'(mem_req), 32'd0);

        // sh 0x106 <- 0x1234CAFE, held while mem_ack stays low.
        mem_ack = 1'b0;
        drive(1'b1, 2'b10, 32'h0000_0106, 32'h1234_CAFE);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check("sh_addr",  mem_addr,    32'h0000_0104);
        check("sh_be",    32'(mem_be), 32'b1100);
        check("sh_wdata", mem_wdata,   32'hCAFE_CAFE);
        step();
        check("sh_hold_req",   32'(mem_req), 32'd1);
        check("sh_hold_addr",  mem_addr,     32'h0000_0104);
        check("sh_hold_wdata", mem_wdata,    32'hCAFE_CAFE);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("sh_pop_count", 32'(count), 32'd0);

        // Three back-to-back sw with no ack: the third is held by backpressure.
        drive(1'b1, 2'b00, 32'h0000_0200, 32'h1111_1111);
        step();
        check("bp_count1", 32'(count), 32'd1);
        drive(1'b1, 2'b00, 32'h0000_0204, 32'h2222_2222);
        step();
        check("bp_count2", 32'(count),    32'd2);
        check("bp_ready0", 32'(st_ready), 32'd0);
        drive(1'b1, 2'b00, 32'h0000_0208, 32'h3333_3333);
        step();
        check("bp_held_count", 32'(count), 32'd2);
        check("bp_head_a",     mem_addr,   32'h0000_0200);
        check("bp_head_a_d",   mem_wdata,  32'h1111_1111);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("bp_ack_count", 32'(count),    32'd1);
        check("bp_ack_ready", 32'(st_ready), 32'd1);
        check("bp_head_b",    mem_addr,      32'h0000_0204);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check("bp_third_count", 32'(count), 32'd2);
        check("bp_head_b_held", mem_addr,   32'h0000_0204);
        mem_ack = 1'b1;
        step();
        check("bp_head_c",   mem_addr,   32'h0000_0208);
        check("bp_head_c_d", mem_wdata,  32'h3333_3333);
        check("bp_count_c",  32'(count), 32'd1);

        // count=1: enqueue and pop in the same cycle.
        drive(1'b1, 2'b00, 32'h0000_030C, 32'h4444_4444);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check("pp_count", 32'(count),   32'd1);
        check("pp_req",   32'(mem_req), 32'd1);
        check("pp_addr",  mem_addr,     32'h0000_030C);
        check("pp_wdata", mem_wdata,    32'h4444_4444);
        step();
        mem_ack = 1'b0;
        check("pp_drain_count", 32'(count),   32'd0);
        check("pp_drain_req",   32'(mem_req), 32'd0);

        // Asynchronous reset with two entries buffered.
        drive(1'b1, 2'b00, 32'h0000_0400, 32'h5555_5555);
        step();
        drive(1'b1, 2'b00, 32'h0000_0404, 32'h6666_6666);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check("ar_pre_count", 32'(count),   32'd2);
        check("ar_pre_req",   32'(mem_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_req",   32'(mem_req),  32'd0);
        check("ar_count", 32'(count),    32'd0);
        check("ar_ready", 32'(st_ready), 32'd1);
        check("ar_addr",  mem_addr,      32'h0);
        #2;
        reset_n = 1'b1;
        step();
        check("ar_post_count", 32'(count), 32'd0);

        // sw to a misaligned address.
        drive(1'b1, 2'b00, 32'h0000_0002, 32'hDEAD_BEEF);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
`ifdef STORE_ALIGN_CHK_EN
        check("mis_pulse", 32'(misalign), 32'd1);
        check("mis_count", 32'(count),    32'd0);
        check("mis_req",   32'(mem_req),  32'd0);
        step();
        check("mis_clear", 32'(misalign), 32'd0);
        check("mis_req2",  32'(mem_req),  32'd0);
`else
        check("mis_pulse", 32'(misalign), 32'd0);
        check("mis_count", 32'(count),    32'd1);
        check("mis_addr",  mem_addr,      32'h0000_0000);
        check("mis_be",    32'(mem_be),   32'b1111);
        check("mis_wdata", mem_wdata,     32'hDEAD_BEEF);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("mis_pop_count", 32'(count), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_buf.md
STORE_BUF -- requirements
Module: store_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 2, giving the number of store-buffer entries (power of two, 2..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port st_valid, input, 1, store request from the MEM stage.
REQ-005 SHALL have port st_ready, output, 1, buffer can accept a request this cycle.
REQ-006 SHALL have port st_addr, input, 32, byte address of the store.
REQ-007 SHALL have port st_data, input, 32, register data; low byte or halfword holds the value for sb/sh.
REQ-008 SHALL have port st_op, input, 2, store type: 00 sw, 01 sb, 10 sh, 11 treated as sw.
REQ-009 SHALL have port mem_req, output, 1, write request to data memory.
REQ-010 SHALL have port mem_ack, input, 1, memory accepted the head write this cycle.
REQ-011 SHALL have port mem_addr, output, 32, word address with bits [1:0] forced to 0.
REQ-012 SHALL have port mem_wdata, output, 32, lane-replicated write data.
REQ-013 SHALL have port mem_be, output, 4, byte enables; bit i enables byte lane i (bits 8i+7:8i).
REQ-014 SHALL have port count, output, clog2(DEPTH)+1, number of occupied entries.
REQ-015 SHALL have port misalign, output, 1, misaligned-store pulse (tied 0 when STORE_ALIGN_CHK_EN is undefined).

Function
REQ-016 SHALL enqueue one entry when st_valid and st_ready are both high; st_ready = (count != DEPTH), with no full-state bypass.
REQ-017 SHALL compute at enqueue: sw -> be 1111, wdata = st_data; sb -> be = 0001 << st_addr[1:0], wdata = {4{st_data[7:0]}}; sh -> be = 0011 if st_addr[1]=0, else 1100, wdata = {2{st_data[15:0]}}.
REQ-018 SHALL store per entry the word address, wdata and be, in FIFO order.
REQ-019 SHALL use a two-state FSM: IDLE (mem_req=0) and ISSUE (mem_req=1, outputs from the head entry).
REQ-020 SHALL move IDLE->ISSUE on the edge at which count becomes non-zero, so mem_req rises one cycle after the first enqueue into an empty buffer.
REQ-021 SHALL pop the head when mem_req and mem_ack are both high, and stay in ISSUE if entries remain, presenting the next head in the following cycle.
REQ-022 SHALL return ISSUE->IDLE when the last entry pops and no enqueue occurs in that cycle.
REQ-023 SHALL hold mem_addr, mem_wdata and mem_be stable while mem_req=1 and mem_ack=0.
REQ-024 SHALL leave count unchanged on a simultaneous enqueue and pop, with pointers wrapping modulo DEPTH.
REQ-025 SHALL ignore mem_ack while mem_req=0.

Reset
REQ-026 SHALL, on reset_n low, immediately clear the FSM to IDLE, count=0, pointers=0, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, misalign=0, st_ready=1.
REQ-027 SHALL discard buffered stores on reset mid-operation; the first post-reset store SHALL be accepted on the first rising edge after reset_n goes high.

Configuration
REQ-028 SHALL, with STORE_ALIGN_CHK_EN defined, treat sw with st_addr[1:0]!=0 and sh with st_addr[0]=1 as misaligned: the store is not enqueued and misalign is high for exactly the cycle after the accepting handshake; st_ready is unaffected.
REQ-029 SHALL, with STORE_ALIGN_CHK_EN undefined, enqueue all stores, ignore st_addr[1:0] for sw and st_addr[0] for sh, and tie misalign to 0.

Verification
REQ-030 SHALL cover: sb with addr 0x00000013 and data 0x000000AB, mem_ack=1 -> one cycle later mem_req=1, mem_addr=0x00000010, mem_be=1000, mem_wdata=0xABABABAB; popped that cycle.
REQ-031 SHALL cover: sh to 0x00000106 with data 0x1234CAFE -> mem_be=1100, mem_wdata=0xCAFECAFE, mem_addr=0x00000104.
REQ-032 SHALL cover: DEPTH=2, mem_ack=0, three back-to-back sw -> st_ready low after two accepts, count=2, third held; mem_ack=1 for one cycle -> count=1, st_ready=1, third accepted, order preserved.
REQ-033 SHALL cover: count=1 with simultaneous enqueue and ack -> count stays 1, mem_req stays 1, new entry presented the next cycle.
REQ-034 SHALL cover: reset_n low while count=2 and mem_req=1 -> mem_req=0 and count=0 without waiting for a clock edge.
REQ-035 SHALL cover, with STORE_ALIGN_CHK_EN: sw to 0x00000002 -> misalign=1 for one cycle, count stays 0, mem_req stays 0; without the macro -> written with mem_addr=0x00000000 and mem_be=1111.
